// File: rtl/rr_arb8_ctrl.sv
// Eight-client round-robin arbiter with registered one-hot and binary grant.
// Define RR_ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_arb8_ctrl #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enb,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [2:0] ptr;
    logic [2:0] ptr_d;
    logic [7:0] gnt_d;
    logic [2:0] idx_d;
    logic       vld_d;
    logic       tmo_d;
    logic [2:0] pick;
    logic       any;
    logic       expire;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range 1..255");
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_d;

    assign expire = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Descending scan so the lowest offset from ptr wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                pick = ptr + 3'(k);
                any  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        vld_d   = gnt_vld;
        ptr_d   = ptr;
        tmo_d   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        hold_d  = hold_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (enb && any) begin
                    state_d = GRANT;
                    gnt_d   = 8'b1 << pick;
                    idx_d   = pick;
                    vld_d   = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (expire || !req[gnt_idx] || !enb) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = gnt_idx + 3'd1;
                    tmo_d   = expire;
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = hold_cnt + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            tmo     <= 1'b0;
            ptr     <= '0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            gnt_vld <= vld_d;
            tmo     <= tmo_d;
            ptr     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Randomized and directed bench for rr_arb8_ctrl against a client-level model.
// Works with RR_ARB_TIMEOUT_EN either defined or undefined.
module tb_rr_arb8_ctrl;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       enb;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       tmo;

    int n_cmp;
    int n_err;

    // Model: current owner (-1 = none), next search start, cycles held.
    int owner;
    int nxt;
    int held;
    bit m_tmo;

`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    rr_arb8_ctrl #(.MAX_HOLD(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enb     (enb),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic mdl_reset();
        owner = -1;
        nxt   = 0;
        held  = 0;
        m_tmo = 1'b0;
    endtask

    task automatic mdl_step(input logic [7:0] r, input logic e);
        bit timed;
        m_tmo = 1'b0;
        if (owner < 0) begin
            if (e && r != 0) begin
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = (nxt + k) % 8;
                    if (r[c]) begin
                        owner = c;
                        held  = 1;
                        break;
                    end
                end
            end
        end else begin
            timed = TO_EN && (held == HOLD);
            if (timed || !r[owner] || !e) begin
                nxt   = (owner + 1) % 8;
                owner = -1;
                m_tmo = timed;
            end else begin
                held++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (owner >= 0) ? 8'(1 << owner) : 8'h00;
        ei = (owner >= 0) ? 3'(owner) : 3'd0;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(owner >= 0));
        chk({tag, ".tmo"}, 32'(tmo), 32'(m_tmo));
    endtask

    // Inputs change at the negedge; outputs checked at the following negedge.
    task automatic cyc(input logic [7:0] r, input logic e, input string tag);
        req = r;
        enb = e;
        mdl_step(r, e);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int cnt;
        logic [7:0] rr;
        logic       ee;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        enb   = 1'b0;
        req   = 8'h00;
        mdl_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Single request and release.
        cyc(8'h20, 1'b1, "single");
        chk("single.gnt20", 32'(gnt), 32'h20);
        chk("single.idx5", 32'(gnt_idx), 32'd5);
        cyc(8'h20, 1'b1, "single_hold");
        cyc(8'h00, 1'b1, "single_rel");
        chk("single.clear", 32'(gnt), 32'h00);

        // Asynchronous reset between edges while granted.
        cyc(8'h10, 1'b1, "pre_rst");
        cyc(8'h10, 1'b1, "pre_rst2");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.gnt", 32'(gnt), 32'h00);
        chk("arst.idx", 32'(gnt_idx), 32'd0);
        chk("arst.vld", 32'(gnt_vld), 32'd0);
        chk("arst.tmo", 32'(tmo), 32'd0);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness with wrap; first grant after reset is client 0.
        for (int i = 0; i < 9; i++) begin
            cyc(8'hFF, 1'b1, "fair");
            chk("fair.order", 32'(gnt_idx), 32'(i % 8));
            cyc(8'hFF, 1'b1, "fair_hold");
            cyc(8'hFF & ~(8'h01 << (i % 8)), 1'b1, "fair_gap");
            chk("fair.gap", 32'(gnt_vld), 32'd0);
        end

        // Pointer moves past the released client.
        cyc(8'h00, 1'b1, "ptr_idle");
        cyc(8'h20, 1'b1, "ptr5");
        cyc(8'h00, 1'b1, "ptr5_rel");
        cyc(8'h41, 1'b1, "ptr6");
        chk("ptr.first6", 32'(gnt_idx), 32'd6);
        cyc(8'h01, 1'b1, "ptr6_rel");
        cyc(8'h01, 1'b1, "ptr0");
        chk("ptr.then0", 32'(gnt), 32'h01);
        cyc(8'h00, 1'b1, "ptr_done");

        // Enable gating.
        repeat (3) cyc(8'h08, 1'b0, "enb_off");
        chk("enb.nogrant", 32'(gnt_vld), 32'd0);
        cyc(8'h08, 1'b1, "enb_on");
        chk("enb.grant", 32'(gnt), 32'h08);
        cyc(8'h08, 1'b0, "enb_drop");
        chk("enb.clear", 32'(gnt), 32'h00);
        cyc(8'h00, 1'b1, "enb_done");

        // Hold limit behaviour with a constant request.
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(8'h04, 1'b1, "hold");
            if (gnt == 8'h04) cnt++;
        end
        chk("hold.cycles", 32'(cnt), TO_EN ? 32'd4 : 32'd5);
        chk("hold.tmo", 32'(tmo), 32'(TO_EN));
        cyc(8'h04, 1'b1, "hold_regrant");
        chk("hold.regrant", 32'(gnt), 32'h04);
        cyc(8'h00, 1'b1, "hold_done");

        // Randomized traffic with sticky requests.
        rr = 8'h00;
        ee = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rr = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rr = rr & 8'($urandom);
            ee = ($urandom_range(0, 19) != 0);
            cyc(rr, ee, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_err);
        $finish;
    end

endmodule
